// File: rtl/led_display_pkg.sv
// Shared types and width helpers for the LED panel scan path.
package led_display_pkg;

   localparam int BRIGHT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      BLANK,
      LATCH,
      DISPLAY
   } scan_state_t;

   function automatic int addr_width(input int num_rows);
      return (num_rows / 2 > 1) ? $clog2(num_rows / 2) : 1;
   endfunction

   function automatic int plane_width(input int bit_depth);
      return (bit_depth > 1) ? $clog2(bit_depth) : 1;
   endfunction

   // Wide enough to hold the longest plane period without wrapping.
   function automatic int dwell_width(input int base_cycles, input int bit_depth);
      return $clog2((base_cycles << bit_depth) + 1);
   endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Loadable down-counter; done_out marks the final cycle of a loaded duration.
module led_dwell_timer #(
   parameter int CNT_W = 13
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             load_in,
   input  logic [CNT_W-1:0] load_value_in,
   output logic [CNT_W-1:0] count_out,
   output logic             done_out
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         count_reg <= '0;
      end else if (load_in) begin
         count_reg <= load_value_in;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CNT_W'(1);
      end
   end

   assign count_out = count_reg;
   assign done_out  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/led_scan_scheduler.sv
// BCM row/plane sequencer: shift, blank, latch, then plane-weighted display window.
module led_scan_scheduler
   import led_display_pkg::*;
#(
   parameter int  NUM_ROWS     = 32,
   parameter int  BIT_DEPTH    = 8,
   parameter int  BASE_CYCLES  = 16,
   parameter int  BLANK_CYCLES = 4,
   parameter int  LATCH_CYCLES = 2,
   localparam int ADDR_W       = addr_width(NUM_ROWS),
   localparam int PLANE_W      = plane_width(BIT_DEPTH)
) (
   input  logic                clk_in,
   input  logic                reset_in,
   input  logic                enable_in,
   input  logic [BRIGHT_W-1:0] brightness_in,
   output logic                shift_start_out,
   input  logic                shift_done_in,
   output logic [ADDR_W-1:0]   row_sel_out,
   output logic [PLANE_W-1:0]  plane_sel_out,
   output logic [ADDR_W-1:0]   addr_out,
   output logic                latch_enable_out,
   output logic                output_enable_out,
   output logic                frame_start_out,
   output logic                busy_out
);

   localparam int CNT_W  = dwell_width(BASE_CYCLES, BIT_DEPTH);
   localparam int PROD_W = CNT_W + BRIGHT_W;

   scan_state_t         state_reg, state_next;
   logic [ADDR_W-1:0]   row_reg, row_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [PLANE_W-1:0]  plane_reg, plane_next;
   logic [BRIGHT_W-1:0] bright_reg, bright_next;
   logic [CNT_W-1:0]    off_reg, off_next;
   logic                shift_start_reg, shift_start_next;
   logic                frame_start_reg, frame_start_next;

   logic                dwell_load;
   logic [CNT_W-1:0]    dwell_value;
   logic [CNT_W-1:0]    dwell_count;
   logic                dwell_done;

   logic [CNT_W-1:0]    period;
   logic [PROD_W-1:0]   product;
   logic [CNT_W-1:0]    on_cycles;
   logic                plane_last;
   logic                row_last;

   led_dwell_timer #(
      .CNT_W (CNT_W)
   ) u_dwell (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .load_in       (dwell_load),
      .load_value_in (dwell_value),
      .count_out     (dwell_count),
      .done_out      (dwell_done)
   );

   // Full-width product so the >> 8 sees every bit of period * brightness.
   assign period     = CNT_W'(BASE_CYCLES) << plane_reg;
   assign product    = PROD_W'(period) * PROD_W'(bright_reg);
   assign on_cycles  = product[PROD_W-1:BRIGHT_W];
   assign plane_last = (plane_reg == PLANE_W'(BIT_DEPTH - 1));
   assign row_last   = (row_reg == ADDR_W'(NUM_ROWS / 2 - 1));

   always_comb begin
      state_next       = state_reg;
      row_next         = row_reg;
      addr_next        = addr_reg;
      plane_next       = plane_reg;
      bright_next      = bright_reg;
      off_next         = off_reg;
      shift_start_next = 1'b0;
      frame_start_next = 1'b0;
      dwell_load       = 1'b0;
      dwell_value      = '0;

      case (state_reg)
         IDLE: begin
            if (enable_in) begin
               state_next       = SHIFT;
               shift_start_next = 1'b1;
               frame_start_next = 1'b1;
               bright_next      = brightness_in;
            end
         end
         SHIFT: begin
            if (shift_done_in) begin
               state_next  = BLANK;
               dwell_load  = 1'b1;
               dwell_value = CNT_W'(BLANK_CYCLES);
            end
         end
         BLANK: begin
            if (dwell_done) begin
               state_next  = LATCH;
               dwell_load  = 1'b1;
               dwell_value = CNT_W'(LATCH_CYCLES);
               addr_next   = row_reg;
            end
         end
         LATCH: begin
            if (dwell_done) begin
               state_next  = DISPLAY;
               dwell_load  = 1'b1;
               dwell_value = period;
               off_next    = period - on_cycles;
            end
         end
         DISPLAY: begin
            if (dwell_done) begin
               if (plane_last) begin
                  plane_next = '0;
                  row_next   = row_last ? '0 : row_reg + ADDR_W'(1);
               end else begin
                  plane_next = plane_reg + PLANE_W'(1);
               end
               if (enable_in) begin
                  state_next       = SHIFT;
                  shift_start_next = 1'b1;
                  if (plane_last && row_last) begin
                     frame_start_next = 1'b1;
                     bright_next      = brightness_in;
                  end
               end else begin
                  state_next = IDLE;
                  row_next   = '0;
                  plane_next = '0;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_reg       <= IDLE;
         row_reg         <= '0;
         addr_reg        <= '0;
         plane_reg       <= '0;
         bright_reg      <= '0;
         off_reg         <= '0;
         shift_start_reg <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         row_reg         <= row_next;
         addr_reg        <= addr_next;
         plane_reg       <= plane_next;
         bright_reg      <= bright_next;
         off_reg         <= off_next;
         shift_start_reg <= shift_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

   // The timer counts P..1 in DISPLAY, so lit while more than P-On cycles remain.
   assign output_enable_out = (state_reg == DISPLAY) && (dwell_count > off_reg);
   assign latch_enable_out  = (state_reg == LATCH);
   assign busy_out          = (state_reg != IDLE);
   assign shift_start_out   = shift_start_reg;
   assign frame_start_out   = frame_start_reg;
   assign row_sel_out       = row_reg;
   assign plane_sel_out     = plane_reg;
   assign addr_out          = addr_reg;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Directed bench for led_scan_scheduler at default parameters (16 row pairs, 8 planes).
module tb_led_scan_scheduler;

   logic       clk_in = 1'b0;
   logic       reset_in;
   logic       enable_in;
   logic [7:0] brightness_in;
   logic       shift_start_out;
   logic       shift_done_in;
   logic [3:0] row_sel_out;
   logic [2:0] plane_sel_out;
   logic [3:0] addr_out;
   logic       latch_enable_out;
   logic       output_enable_out;
   logic       frame_start_out;
   logic       busy_out;

   logic [31:0] all_out;
   int n_assert = 0;
   int n_fail   = 0;

   int bl, le, disp, on, addr, bad;
   int errs, ss, fs, on_sum;
   int on255 [8] = '{15, 31, 63, 127, 255, 510, 1020, 2040};

   always #5 clk_in = ~clk_in;

   led_scan_scheduler dut (
      .clk_in            (clk_in),
      .reset_in          (reset_in),
      .enable_in         (enable_in),
      .brightness_in     (brightness_in),
      .shift_start_out   (shift_start_out),
      .shift_done_in     (shift_done_in),
      .row_sel_out       (row_sel_out),
      .plane_sel_out     (plane_sel_out),
      .addr_out          (addr_out),
      .latch_enable_out  (latch_enable_out),
      .output_enable_out (output_enable_out),
      .frame_start_out   (frame_start_out),
      .busy_out          (busy_out)
   );

   assign all_out = {16'd0, shift_start_out, frame_start_out, latch_enable_out,
                     output_enable_out, busy_out, row_sel_out, plane_sel_out, addr_out};

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Starts in the first SHIFT cycle; PHY completes at once. Returns at the next
   // SHIFT entry or at IDLE, with the durations seen in each phase.
   task automatic run_plane(input bit spurious, input bit drop,
                            output int o_bl, output int o_le, output int o_disp,
                            output int o_on, output int o_addr, output int o_bad);
      int  phase = 0;
      int  n = 0;
      bit  off_seen = 0;
      o_bl = 0; o_le = 0; o_disp = 0; o_on = 0; o_addr = -1; o_bad = 0;
      shift_done_in = 1'b1;
      step();
      shift_done_in = 1'b0;
      while (n < 5000) begin
         if (phase == 0) begin
            if (latch_enable_out) phase = 1;
            else o_bl++;
         end
         if (phase == 1) begin
            if (latch_enable_out) begin
               o_le++;
               o_addr = int'(addr_out);
            end else phase = 2;
         end
         if (phase == 2) begin
            if (shift_start_out || !busy_out) break;
            o_disp++;
            if (latch_enable_out) o_bad++;
            if (output_enable_out) begin
               o_on++;
               if (off_seen) o_bad++;
            end else off_seen = 1;
            if (o_disp == 1 && spurious) shift_done_in = 1'b1;
            if (o_disp == 1 && drop) enable_in = 1'b0;
         end else if (output_enable_out) o_bad++;
         step();
         shift_done_in = 1'b0;
         n++;
      end
      if (n >= 5000) o_bad += 1000;
   endtask

   task automatic run_span(input int count, input int row0, input int plane0, input int b,
                           input int chg_row, input int chg_val,
                           output int o_errs, output int o_ss, output int o_fs, output int o_on_sum);
      int r = row0;
      int p = plane0;
      int s_bl, s_le, s_disp, s_on, s_addr, s_bad;
      o_errs = 0; o_ss = 0; o_fs = 0; o_on_sum = 0;
      for (int k = 0; k < count; k++) begin
         if (shift_start_out) o_ss++;
         if (frame_start_out) o_fs++;
         if (int'(row_sel_out) != r || int'(plane_sel_out) != p) o_errs++;
         if (r == chg_row) brightness_in = 8'(chg_val);
         run_plane(1'b0, 1'b0, s_bl, s_le, s_disp, s_on, s_addr, s_bad);
         if (s_bl != 4 || s_le != 2 || s_disp != (16 << p) || s_on != (((16 << p) * b) >> 8)
             || s_addr != r || s_bad != 0) o_errs++;
         o_on_sum += s_on;
         p++;
         if (p == 8) begin
            p = 0;
            r = (r + 1) % 16;
         end
      end
   endtask

   initial begin
      reset_in      = 1'b1;
      enable_in     = 1'b1;
      brightness_in = 8'd128;
      shift_done_in = 1'b0;

      // Reset held with enable high
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("reset_outputs_%0d", i), all_out, 32'd0);
      end
      reset_in = 1'b0;
      step();
      chk("start_frame_pulse", frame_start_out, 1);
      chk("start_shift_pulse", shift_start_out, 1);
      chk("start_row", row_sel_out, 0);
      chk("start_plane", plane_sel_out, 0);
      chk("start_busy", busy_out, 1);

      // Row 0 plane 0 at brightness 128, PHY done 10 cycles after start
      step();
      chk("shift_pulse_once", shift_start_out, 0);
      repeat (8) step();
      chk("shift_wait_oe", output_enable_out, 0);
      chk("shift_wait_busy", busy_out, 1);
      run_plane(1'b0, 1'b0, bl, le, disp, on, addr, bad);
      chk("p0_blank", bl, 4);
      chk("p0_latch", le, 2);
      chk("p0_addr", addr, 0);
      chk("p0_display", disp, 16);
      chk("p0_on", on, 8);
      chk("p0_shape", bad, 0);
      chk("p1_shift_pulse", shift_start_out, 1);
      chk("p1_plane_sel", plane_sel_out, 1);
      chk("p1_no_frame", frame_start_out, 0);

      // Plane 1 with a spurious shift_done during DISPLAY
      run_plane(1'b1, 1'b0, bl, le, disp, on, addr, bad);
      chk("spurious_display", disp, 32);
      chk("spurious_on", on, 16);
      chk("spurious_shape", bad, 0);
      chk("p2_plane_sel", plane_sel_out, 2);

      // Run on to row 5 plane 3, then drop enable mid-DISPLAY
      run_span(41, 0, 2, 128, -1, 0, errs, ss, fs, on_sum);
      chk("span_a_errors", errs, 0);
      chk("span_a_shift_starts", ss, 41);
      chk("drop_at_row", row_sel_out, 5);
      chk("drop_at_plane", plane_sel_out, 3);
      run_plane(1'b0, 1'b1, bl, le, disp, on, addr, bad);
      chk("drop_display_full", disp, 128);
      chk("drop_on", on, 64);
      chk("drop_idle_busy", busy_out, 0);
      chk("drop_idle_oe", output_enable_out, 0);
      repeat (3) step();
      chk("idle_no_shift", shift_start_out, 0);
      chk("idle_row", row_sel_out, 0);
      chk("idle_plane", plane_sel_out, 0);

      // Re-enable at brightness 255: one full row, planes 0..7
      brightness_in = 8'd255;
      enable_in = 1'b1;
      step();
      chk("reen_frame_pulse", frame_start_out, 1);
      chk("reen_shift_pulse", shift_start_out, 1);
      chk("reen_row", row_sel_out, 0);
      chk("reen_plane", plane_sel_out, 0);
      for (int p = 0; p < 8; p++) begin
         run_plane(1'b0, 1'b0, bl, le, disp, on, addr, bad);
         chk($sformatf("b255_p%0d_display", p), disp, 16 << p);
         chk($sformatf("b255_p%0d_on", p), on, on255[p]);
      end
      chk("row1_sel", row_sel_out, 1);

      // Reset during SHIFT
      step();
      reset_in = 1'b1;
      step();
      chk("midreset_outputs", all_out, 32'd0);
      step();
      chk("midreset_hold", all_out, 32'd0);
      reset_in = 1'b0;
      brightness_in = 8'd0;
      step();
      chk("restart_frame_pulse", frame_start_out, 1);
      chk("restart_shift_pulse", shift_start_out, 1);
      chk("restart_row", row_sel_out, 0);

      // Full frame at brightness 0; brightness raised at row 8 must wait a frame
      run_span(128, 0, 0, 0, 8, 255, errs, ss, fs, on_sum);
      chk("frame_errors", errs, 0);
      chk("frame_shift_starts", ss, 128);
      chk("frame_starts", fs, 1);
      chk("frame_oe_total", on_sum, 0);
      chk("next_frame_pulse", frame_start_out, 1);
      chk("last_addr", addr_out, 15);
      chk("next_frame_row", row_sel_out, 0);
      run_plane(1'b0, 1'b0, bl, le, disp, on, addr, bad);
      chk("next_frame_addr_wrap", addr, 0);
      chk("next_frame_on", on, 15);
      chk("next_frame_display", disp, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/led_scan_scheduler.md
Name: led_scan_scheduler

Overview:
Frame/row sequencer for the HUB75-style LED panel. It drives binary-code-modulation (BCM) scanning: for every row pair and bit-plane it starts the shift PHY, blanks, latches, then lights the row for a plane-weighted time. It owns addr/LE/OE, exports the row/plane index to the framebuffer read side, and sits between the pattern/framebuffer logic and the shift PHY.

Parameters:
NUM_ROWS, 32, panel rows; scanned as NUM_ROWS/2 row pairs (top/bottom halves).
BIT_DEPTH, 8, colour bits per channel, i.e. the number of BCM planes.
BASE_CYCLES, 16, clk_in cycles of on-window for plane 0 (LSB); plane p window = BASE_CYCLES << p.
BLANK_CYCLES, 4, OE-low dead time before latch; must be >= 1.
LATCH_CYCLES, 2, LE pulse width; must be >= 1.

Ports:
clk_in  in  1  system clock; the only clock.
reset_in  in  1  reset, synchronous, active-high.
enable_in  in  1  run scanning; sampled at plane boundaries.
brightness_in  in  8  global dimming; latched at frame start.
shift_start_out  out  1  one-cycle pulse: PHY begins shifting row_sel_out/plane_sel_out.
shift_done_in  in  1  one-cycle pulse from PHY: row fully shifted.
row_sel_out  out  ADDR_W  row pair being shifted (framebuffer read address); ADDR_W = $clog2(NUM_ROWS/2).
plane_sel_out  out  PLANE_W  bit-plane being shifted; PLANE_W = $clog2(BIT_DEPTH).
addr_out  out  ADDR_W  panel row address (row currently latched).
latch_enable_out  out  1  LE, active-high.
output_enable_out  out  1  1 = LEDs lit. Any board-level inversion is done outside this block.
frame_start_out  out  1  one-cycle pulse on SHIFT entry for row 0, plane 0.
busy_out  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; row, plane and counters = 0. All outputs 0, including addr_out = 0 and OE = 0. Reset mid-operation aborts immediately; no shift_start_out is issued in the reset cycle.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE -> SHIFT when enable_in = 1. On that entry: brightness_in is latched into bright_q, and frame_start_out pulses.
- SHIFT:
  - shift_start_out pulses exactly once, in the first SHIFT cycle.
  - row_sel_out/plane_sel_out are stable from SHIFT entry until DISPLAY exit.
  - Stays in SHIFT until shift_done_in = 1, then -> BLANK next cycle.
  - shift_done_in seen in any other state is ignored.
- BLANK: OE = 0 for BLANK_CYCLES, then -> LATCH.
- LATCH:
  - addr_out <= row_sel_out on the entry cycle.
  - LE = 1 for LATCH_CYCLES, then -> DISPLAY. LE = 0 in every other state.
- DISPLAY:
  - Period P = BASE_CYCLES << plane. On = (P * bright_q) >> 8, computed at entry with full-width product, no truncation before the shift.
  - OE = 1 for the first On cycles, then 0 for the remaining P - On cycles. Total time in DISPLAY = P cycles.
  - bright_q = 0 -> OE never asserted.
- Advance, at DISPLAY exit:
  - plane+1. On plane wrap (BIT_DEPTH-1 -> 0), row+1. On row wrap (NUM_ROWS/2-1 -> 0), the frame is complete.
  - If enable_in = 1 -> SHIFT; a new frame re-latches brightness and pulses frame_start_out.
  - If enable_in = 0 -> IDLE, with row and plane reset to 0.
  - enable_in deassertion never truncates the current DISPLAY or a pending shift.
- OE is 0 in every state except DISPLAY, so OE and LE are never both 1.
- Counter width: $clog2((BASE_CYCLES << BIT_DEPTH) + 1); no wrap within a period.
- busy_out = (state != IDLE).

Decomposition:
- led_display_pkg holds:
  - scan_state_t enum (IDLE/SHIFT/BLANK/LATCH/DISPLAY);
  - width helper functions for ADDR_W/PLANE_W;
  - BRIGHT_W = 8.
- One sub-module: led_dwell_timer, a loadable down-counter with done pulse, reused for the BLANK, LATCH and DISPLAY durations.
- The on-window compare stays in the scheduler.

Test Plan:
1. Reset held 3 cycles with enable_in = 1 -> all outputs 0, no shift_start_out. Release -> frame_start_out and shift_start_out in the same cycle, row_sel_out = 0, plane_sel_out = 0.
2. brightness = 128, PHY done 10 cycles after start, plane 0 -> 4 cycles OE = 0 (blank), LE = 1 for 2 cycles, addr_out = 0, then OE = 1 for 8 cycles and 0 for 8 cycles; next shift_start_out has plane_sel_out = 1.
3. brightness = 255, plane 7 -> DISPLAY lasts 2048 cycles with OE = 1 for exactly 2040. brightness = 0 -> OE never 1 over a full frame.
4. Full frame (16 rows x 8 planes) -> exactly 128 shift_start_out pulses; addr_out steps 0..15 then wraps to 0; exactly one frame_start_out per frame; brightness_in changed mid-frame takes effect only on the next frame.
5. enable_in dropped mid-DISPLAY at row 5, plane 3 -> DISPLAY completes its full 128 cycles, then IDLE with busy_out = 0 and OE = 0. Re-enable -> restarts at row 0, plane 0 with frame_start_out.
6. Spurious shift_done_in during DISPLAY, plus reset asserted mid-SHIFT -> the spurious pulse causes no state change; after reset all outputs are 0 next cycle and scanning restarts cleanly at row 0.
